// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin merge of ALU and load writebacks
// into a single registered write port, plus a pending-write scoreboard for decode.
module regfile_wb_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        reg_we,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  input  logic        mark_valid,
  input  logic [4:0]  mark_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        stall,
  output logic [31:0] pending
);

  // Handshake: a source transfers when valid && ready at posedge clk. While
  // valid && !ready it must hold rd/data stable. ready depends only on the two
  // valids and the owner bit, so a source is never throttled by the write port.

  // owner = 0: load wins a tie; owner = 1: ALU wins a tie.
  logic        owner;
  logic        tie;
  logic        accept;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [31:0] pending_next;

  always_comb begin
    tie       = alu_valid && ld_valid;
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!rst) begin
      alu_ready = alu_valid && (!ld_valid || owner);
      ld_ready  = ld_valid && (!alu_valid || !owner);
    end
  end

  always_comb begin
    accept   = alu_ready || ld_ready;
    sel_rd   = alu_ready ? alu_rd   : ld_rd;
    sel_data = alu_ready ? alu_data : ld_data;
  end

  // Clear before set so a same-edge mark of a completing register survives.
  always_comb begin
    pending_next = pending;
    if (accept && (sel_rd != 5'd0)) pending_next[sel_rd] = 1'b0;
    if (mark_valid && (mark_rd != 5'd0)) pending_next[mark_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= PRIO_INIT;
      reg_we  <= 1'b0;
      w_addr  <= 5'd0;
      w_data  <= 32'd0;
      pending <= 32'd0;
    end else begin
      if (accept && tie) owner <= ~owner;
      reg_we  <= accept && (sel_rd != 5'd0);
      if (accept && (sel_rd != 5'd0)) begin
        w_addr <= sel_rd;
        w_data <= sel_data;
      end
      pending <= pending_next;
    end
  end

  // No bypass: a register completing this cycle still stalls until its edge.
  always_comb begin
    stall = !rst && (pending[rs1_addr] || pending[rs2_addr]);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: one task per scenario, inline checks.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_ready;
  logic        reg_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        mark_valid = 1'b0;
  logic [4:0]  mark_rd = 5'd0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic        stall;
  logic [31:0] pending;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .reg_we(reg_we), .w_addr(w_addr), .w_data(w_data),
    .mark_valid(mark_valid), .mark_rd(mark_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'h22;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %b exp 0", alu_ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready: got %b exp 0", ld_ready); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL rst_reg_we: got %b exp 0", reg_we); end
    checks++; if (w_addr !== 5'd0) begin errors++; $display("FAIL rst_w_addr: got %0d exp 0", w_addr); end
    checks++; if (w_data !== 32'd0) begin errors++; $display("FAIL rst_w_data: got %h exp 0", w_data); end
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL rst_pending: got %h exp 0", pending); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
    rst = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL first_tie_ld_ready: got %b exp 1", ld_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL first_tie_alu_ready: got %b exp 0", alu_ready); end
    tick();
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL c1_reg_we: got %b exp 1", reg_we); end
    checks++; if (w_addr !== 5'd6) begin errors++; $display("FAIL c1_w_addr: got %0d exp 6", w_addr); end
    checks++; if (w_data !== 32'h22) begin errors++; $display("FAIL c1_w_data: got %h exp 22", w_data); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL c1_alu_ready: got %b exp 1", alu_ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL c1_ld_ready: got %b exp 0", ld_ready); end
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL c2_reg_we: got %b exp 1", reg_we); end
    checks++; if (w_addr !== 5'd5) begin errors++; $display("FAIL c2_w_addr: got %0d exp 5", w_addr); end
    checks++; if (w_data !== 32'h11) begin errors++; $display("FAIL c2_w_data: got %h exp 11", w_data); end
    tick();
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL idle_reg_we: got %b exp 0", reg_we); end
    checks++; if (w_addr !== 5'd5) begin errors++; $display("FAIL idle_w_addr_hold: got %0d exp 5", w_addr); end
  endtask

  task automatic test_back_to_back();
    logic       exp_ld;
    logic [4:0] exp_addr;
    logic [31:0] exp_data;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'hB2;
    for (int i = 0; i < 6; i++) begin
      exp_ld   = (i % 2 == 0);
      exp_addr = exp_ld ? 5'd2 : 5'd1;
      exp_data = exp_ld ? 32'hB2 : 32'hA1;
      #1;
      checks++; if (ld_ready !== exp_ld) begin errors++; $display("FAIL rr_ld_ready[%0d]: got %b exp %b", i, ld_ready, exp_ld); end
      checks++; if (alu_ready !== !exp_ld) begin errors++; $display("FAIL rr_alu_ready[%0d]: got %b exp %b", i, alu_ready, !exp_ld); end
      tick();
      if (i == 5) begin alu_valid = 1'b0; ld_valid = 1'b0; end
      checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL rr_reg_we[%0d]: got %b exp 1", i, reg_we); end
      checks++; if (w_addr !== exp_addr) begin errors++; $display("FAIL rr_w_addr[%0d]: got %0d exp %0d", i, w_addr, exp_addr); end
      checks++; if (w_data !== exp_data) begin errors++; $display("FAIL rr_w_data[%0d]: got %h exp %h", i, w_data, exp_data); end
    end
    tick();
  endtask

  task automatic test_stall_clear();
    mark_valid = 1'b1; mark_rd = 5'd7;
    tick();
    mark_valid = 1'b0; rs1_addr = 5'd7;
    #1;
    checks++; if (pending !== 32'h80) begin errors++; $display("FAIL mark7_pending: got %h exp 80", pending); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mark7_stall: got %b exp 1", stall); end
    tick();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL wr7_alu_ready: got %b exp 1", alu_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wr7_nobypass_stall: got %b exp 1", stall); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if (reg_we !== 1'b1 || w_addr !== 5'd7) begin errors++; $display("FAIL wr7_write: got we=%b addr=%0d exp we=1 addr=7", reg_we, w_addr); end
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL wr7_pending: got %h exp 0", pending); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wr7_stall: got %b exp 0", stall); end
    rs1_addr = 5'd0;
    tick();
  endtask

  task automatic test_set_wins();
    mark_valid = 1'b1; mark_rd = 5'd9;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99; rs2_addr = 5'd9;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL sw_ld_ready: got %b exp 1", ld_ready); end
    tick();
    mark_valid = 1'b0;
    #1;
    checks++; if (reg_we !== 1'b1 || w_addr !== 5'd9) begin errors++; $display("FAIL sw_write: got we=%b addr=%0d exp we=1 addr=9", reg_we, w_addr); end
    checks++; if (pending !== 32'h200) begin errors++; $display("FAIL sw_pending: got %h exp 200", pending); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall: got %b exp 1", stall); end
    tick();
    ld_valid = 1'b0;
    #1;
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL sw_cleanup_pending: got %h exp 0", pending); end
    rs2_addr = 5'd0;
  endtask

  task automatic test_x0();
    mark_valid = 1'b1; mark_rd = 5'd3;
    tick();
    mark_rd = 5'd0;
    tick();
    mark_valid = 1'b0;
    #1;
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL x0_mark_pending: got %h exp 8", pending); end
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL x0_ld_ready: got %b exp 1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL x0_reg_we: got %b exp 0", reg_we); end
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL x0_pending: got %h exp 8", pending); end
  endtask

  task automatic test_reset_midstream();
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
    mark_valid = 1'b1; mark_rd = 5'd4;
    tick();
    ld_valid = 1'b0; mark_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44; rs1_addr = 5'd4;
    #1;
    checks++; if (reg_we !== 1'b1 || w_addr !== 5'd3) begin errors++; $display("FAIL mr_pre_write: got we=%b addr=%0d exp we=1 addr=3", reg_we, w_addr); end
    checks++; if (pending !== 32'h10) begin errors++; $display("FAIL mr_pre_pending: got %h exp 10", pending); end
    checks++; if (alu_ready !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL mr_pre_ready: got ready=%b stall=%b exp 1 1", alu_ready, stall); end
    rst = 1'b1;
    #1;
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL mr_reg_we: got %b exp 0", reg_we); end
    checks++; if (pending !== 32'd0) begin errors++; $display("FAIL mr_pending: got %h exp 0", pending); end
    checks++; if (w_addr !== 5'd0 || w_data !== 32'd0) begin errors++; $display("FAIL mr_w_port: got addr=%0d data=%h exp 0 0", w_addr, w_data); end
    checks++; if (alu_ready !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mr_ready: got ready=%b stall=%b exp 0 0", alu_ready, stall); end
    tick();
    tick();
    alu_valid = 1'b0; rs1_addr = 5'd0;
    rst = 1'b0;
    tick();
    checks++; if (reg_we !== 1'b0 || pending !== 32'd0) begin errors++; $display("FAIL mr_post: got we=%b pending=%h exp 0 0", reg_we, pending); end
    alu_valid = 1'b1; ld_valid = 1'b1;
    #1;
    checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL mr_owner: got ld=%b alu=%b exp 1 0", ld_ready, alu_ready); end
    alu_valid = 1'b0; ld_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_clear();
    test_set_wins();
    test_x0();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
